rs_branch_queue: RTL and testbench
==================================

// Module: rs_branch_queue
// PURPOSE
//  In-order reservation queue for branch/jump ops, directly upstream of exunit_branch.
//  Holds dispatched branches and captures missing operands from two result buses (CDB wakeup).
//  Issues the oldest entry once both of its operands are valid.
//  Flushed on misprediction; speculative bits are cleared on correct prediction.
// PARAMETERS
//  DEPTH   4   entries (power of two, >=2); pointer width PTR=$clog2(DEPTH)
//  widths DATA_LEN=32, ADDR_LEN=32, RRF_SEL=6, SPECTAG_LEN=5, ALU_OP_WIDTH=4 from constants.vh
// PORTS
//  clk         in  1            clock, rising edge
//  reset       in  1            synchronous, active-high
//  dp_we       in  1            dispatch one branch this cycle
//  dp_pc/praddr in ADDR_LEN     branch PC / predicted target
//  dp_imm      in  DATA_LEN     immediate
//  dp_src1/2   in  DATA_LEN     operand value, or RRF tag in [RRF_SEL-1:0] when valid=0
//  dp_vld1/2   in  1            operand already valid
//  dp_rrftag   in  RRF_SEL      destination RRF entry;  dp_dstval in 1: writes rd
//  dp_alu_op   in  ALU_OP_WIDTH compare op;  dp_opcode in 7
//  dp_spectag  in  SPECTAG_LEN  one-hot tag;  dp_specbit in 1
//  cdb0/1_we   in  1            result bus valid; cdb0/1_tag in RRF_SEL; cdb0/1_data in DATA_LEN
//  prmiss      in  1            misprediction resolved (from exunit_branch)
//  prsuccess   in  1            correct prediction;  pr_tag in SPECTAG_LEN: resolving branch tag
//  full        out 1            count==DEPTH;  count out PTR+1
//  issue       out 1            head entry issued this cycle
//  ex_*        out              head entry fields (src1, src2, pc, imm, praddr, rrftag, dstval,
//                               alu_op, opcode, spectag, specbit); valid only when issue=1
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all entry valid bits 0; issue=0, full=0. ex_* are don't-care.
//  - Storage is a circular buffer. Dispatch writes at tail; tail++ mod DEPTH; count++.
//  - Dispatch while full (without a same-cycle issue) is illegal: ignored and asserted in simulation.
//  - issue = entry[head].valid & vld1 & vld2 & ~prmiss. Combinational from the head only (strict
//    in-order; no younger entry bypasses the head). Pop at the clock edge: head++, count--.
//    The downstream pipeline register captures ex_*.
//  - Simultaneous dispatch+issue: count is unchanged; legal when full.
//  - Wakeup, applied to each stored operand with vld=0:
//    - if cdbN_we & cdbN_tag==src[RRF_SEL-1:0], then src<=cdbN_data and vld<=1.
//    - cdb0 has priority if both buses match (identical data expected).
//    - Dispatch bypass: a dispatching operand with vld=0 that matches a CDB in the same cycle is
//      written already valid.
//  - A wakeup in cycle T makes the entry issuable in T+1 (no same-cycle wakeup->issue path).
//  - prmiss:
//    - all queued entries are younger than the resolving branch, so the whole queue is flushed.
//    - head=tail=0, count=0, all valid bits 0.
//    - a same-cycle dispatch is discarded; issue is forced to 0 that cycle.
//  - prsuccess: every valid entry whose spectag==pr_tag has specbit cleared, including a
//    same-cycle dispatch. prmiss and prsuccess are mutually exclusive; prmiss wins if both are set.
//  - Reset mid-operation behaves like prmiss and also clears pending state.
//  - Pointer wrap: DEPTH is a power of two, so wrap is a natural overflow of PTR bits.
//    full/empty are derived from count, never from pointer equality.
// STRUCTURE
//  - Shared constants header: DATA_LEN, ADDR_LEN, RRF_SEL, SPECTAG_LEN, ALU_OP_WIDTH and the
//    RV32 opcode defines. No new shared constants.
//  - One sub-module: rs_branch_wakeup (per-operand tag compare + CDB mux), instantiated
//    2*DEPTH+2 times (stored operands + dispatch bypass).
//  - Queue control and storage stay in this module.
// TESTING
//  1. Dispatch BEQ vld1=vld2=1 into empty queue -> issue=1 next cycle, count 1->0, ex_pc==dp_pc.
//  2. Dispatch src1 tag 5 vld1=0; cdb0_we tag 5 data 0x1234 at T -> issue at T+1,
//     ex_src1==0x1234.
//  3. Fill 4 entries, head not ready -> full=1, issue=0. Dispatch+issue in the same cycle ->
//     count stays 4, order preserved.
//  4. Head waiting, entry 1 ready -> no issue until the head wakes. Then both issue in
//     consecutive cycles, in order.
//  5. 3 queued entries, prmiss with dp_we=1 -> count=0 next cycle; the dispatch is discarded.
//  6. Two entries spectag 5'b00010 specbit=1, prsuccess pr_tag=5'b00010 -> both issue with
//     ex_specbit=0.

Source files
------------

// File: rtl/rs_branch_queue_pkg.sv
// Shared widths, opcode constants and the static entry payload for the
// in-order branch reservation queue.
package rs_branch_queue_pkg;

  localparam int DATA_LEN     = 32;
  localparam int ADDR_LEN     = 32;
  localparam int RRF_SEL      = 6;
  localparam int SPECTAG_LEN  = 5;
  localparam int ALU_OP_WIDTH = 4;
  localparam int OPCODE_LEN   = 7;

  localparam logic [OPCODE_LEN-1:0] RV32_BRANCH = 7'b1100011;
  localparam logic [OPCODE_LEN-1:0] RV32_JAL    = 7'b1101111;
  localparam logic [OPCODE_LEN-1:0] RV32_JALR   = 7'b1100111;

  // Fields written once at dispatch and never touched by wakeup.
  typedef struct packed {
    logic [ADDR_LEN-1:0]     pc;
    logic [DATA_LEN-1:0]     imm;
    logic [ADDR_LEN-1:0]     praddr;
    logic [RRF_SEL-1:0]      rrftag;
    logic                    dstval;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [OPCODE_LEN-1:0]   opcode;
    logic [SPECTAG_LEN-1:0]  spectag;
  } info_t;

endpackage

// File: rtl/rs_branch_wakeup.sv
// One operand's CDB wakeup: tag compare against both result buses and the
// resulting value/valid mux. cdb0 wins when both buses match.
module rs_branch_wakeup
  import rs_branch_queue_pkg::*;
(
  input  logic [DATA_LEN-1:0] i_src,
  input  logic                i_vld,
  input  logic                i_cdb0_we,
  input  logic [RRF_SEL-1:0]  i_cdb0_tag,
  input  logic [DATA_LEN-1:0] i_cdb0_data,
  input  logic                i_cdb1_we,
  input  logic [RRF_SEL-1:0]  i_cdb1_tag,
  input  logic [DATA_LEN-1:0] i_cdb1_data,
  output logic [DATA_LEN-1:0] o_src,
  output logic                o_vld
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = ~i_vld & i_cdb0_we & (i_cdb0_tag == i_src[RRF_SEL-1:0]);
  assign w_hit1 = ~i_vld & i_cdb1_we & (i_cdb1_tag == i_src[RRF_SEL-1:0]);

  always_comb begin
    o_src = i_src;
    o_vld = i_vld;
    if (w_hit0) begin
      o_src = i_cdb0_data;
      o_vld = 1'b1;
    end else if (w_hit1) begin
      o_src = i_cdb1_data;
      o_vld = 1'b1;
    end
  end

endmodule

// File: rtl/rs_branch_queue.sv
// In-order branch reservation queue: circular buffer with CDB operand capture,
// head-only issue, full flush on misprediction and spec-bit clearing on success.
module rs_branch_queue
  import rs_branch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR  = $clog2(DEPTH),
  localparam int CNT  = PTR + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dp_we,
  input  logic [ADDR_LEN-1:0]     dp_pc,
  input  logic [ADDR_LEN-1:0]     dp_praddr,
  input  logic [DATA_LEN-1:0]     dp_imm,
  input  logic [DATA_LEN-1:0]     dp_src1,
  input  logic [DATA_LEN-1:0]     dp_src2,
  input  logic                    dp_vld1,
  input  logic                    dp_vld2,
  input  logic [RRF_SEL-1:0]      dp_rrftag,
  input  logic                    dp_dstval,
  input  logic [ALU_OP_WIDTH-1:0] dp_alu_op,
  input  logic [OPCODE_LEN-1:0]   dp_opcode,
  input  logic [SPECTAG_LEN-1:0]  dp_spectag,
  input  logic                    dp_specbit,
  input  logic                    cdb0_we,
  input  logic [RRF_SEL-1:0]      cdb0_tag,
  input  logic [DATA_LEN-1:0]     cdb0_data,
  input  logic                    cdb1_we,
  input  logic [RRF_SEL-1:0]      cdb1_tag,
  input  logic [DATA_LEN-1:0]     cdb1_data,
  input  logic                    prmiss,
  input  logic                    prsuccess,
  input  logic [SPECTAG_LEN-1:0]  pr_tag,
  output logic                    full,
  output logic [CNT-1:0]          count,
  output logic                    issue,
  output logic [DATA_LEN-1:0]     ex_src1,
  output logic [DATA_LEN-1:0]     ex_src2,
  output logic [ADDR_LEN-1:0]     ex_pc,
  output logic [DATA_LEN-1:0]     ex_imm,
  output logic [ADDR_LEN-1:0]     ex_praddr,
  output logic [RRF_SEL-1:0]      ex_rrftag,
  output logic                    ex_dstval,
  output logic [ALU_OP_WIDTH-1:0] ex_alu_op,
  output logic [OPCODE_LEN-1:0]   ex_opcode,
  output logic [SPECTAG_LEN-1:0]  ex_spectag,
  output logic                    ex_specbit
);

  logic [PTR-1:0]      r_head;
  logic [PTR-1:0]      r_tail;
  logic [CNT-1:0]      r_count;
  logic                r_valid   [DEPTH];
  logic [DATA_LEN-1:0] r_src1    [DEPTH];
  logic [DATA_LEN-1:0] r_src2    [DEPTH];
  logic                r_vld1    [DEPTH];
  logic                r_vld2    [DEPTH];
  logic                r_specbit [DEPTH];
  info_t               r_info    [DEPTH];

  logic [DATA_LEN-1:0] w_src1_wk [DEPTH];
  logic [DATA_LEN-1:0] w_src2_wk [DEPTH];
  logic                w_vld1_wk [DEPTH];
  logic                w_vld2_wk [DEPTH];
  logic                w_spec_clr [DEPTH];

  logic [DATA_LEN-1:0] w_dp_src1;
  logic [DATA_LEN-1:0] w_dp_src2;
  logic                w_dp_vld1;
  logic                w_dp_vld2;
  logic                w_dp_specbit;
  logic                w_full;
  logic                w_issue;
  logic                w_dp_acc;

  assign w_full  = (r_count == CNT'(DEPTH));
  // Reset is gated in so a mid-run reset never hands a stale head downstream.
  assign w_issue = r_valid[r_head] & r_vld1[r_head] & r_vld2[r_head] & ~prmiss & ~reset;
  assign w_dp_acc = dp_we & ~prmiss & ~reset & (~w_full | w_issue);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      rs_branch_wakeup u_wk1 (
        .i_src(r_src1[gi]), .i_vld(r_vld1[gi]),
        .i_cdb0_we(cdb0_we), .i_cdb0_tag(cdb0_tag), .i_cdb0_data(cdb0_data),
        .i_cdb1_we(cdb1_we), .i_cdb1_tag(cdb1_tag), .i_cdb1_data(cdb1_data),
        .o_src(w_src1_wk[gi]), .o_vld(w_vld1_wk[gi])
      );
      rs_branch_wakeup u_wk2 (
        .i_src(r_src2[gi]), .i_vld(r_vld2[gi]),
        .i_cdb0_we(cdb0_we), .i_cdb0_tag(cdb0_tag), .i_cdb0_data(cdb0_data),
        .i_cdb1_we(cdb1_we), .i_cdb1_tag(cdb1_tag), .i_cdb1_data(cdb1_data),
        .o_src(w_src2_wk[gi]), .o_vld(w_vld2_wk[gi])
      );
      assign w_spec_clr[gi] = prsuccess & (r_info[gi].spectag == pr_tag);
    end
  endgenerate

  // Dispatch bypass: operands produced on a CDB this cycle enter already valid.
  rs_branch_wakeup u_dp_wk1 (
    .i_src(dp_src1), .i_vld(dp_vld1),
    .i_cdb0_we(cdb0_we), .i_cdb0_tag(cdb0_tag), .i_cdb0_data(cdb0_data),
    .i_cdb1_we(cdb1_we), .i_cdb1_tag(cdb1_tag), .i_cdb1_data(cdb1_data),
    .o_src(w_dp_src1), .o_vld(w_dp_vld1)
  );
  rs_branch_wakeup u_dp_wk2 (
    .i_src(dp_src2), .i_vld(dp_vld2),
    .i_cdb0_we(cdb0_we), .i_cdb0_tag(cdb0_tag), .i_cdb0_data(cdb0_data),
    .i_cdb1_we(cdb1_we), .i_cdb1_tag(cdb1_tag), .i_cdb1_data(cdb1_data),
    .o_src(w_dp_src2), .o_vld(w_dp_vld2)
  );

  assign w_dp_specbit = dp_specbit & ~(prsuccess & (dp_spectag == pr_tag));

  always_ff @(posedge clk) begin
    if (reset || prmiss) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_src1[i] <= w_src1_wk[i];
        r_vld1[i] <= w_vld1_wk[i];
        r_src2[i] <= w_src2_wk[i];
        r_vld2[i] <= w_vld2_wk[i];
        if (w_spec_clr[i]) begin
          r_specbit[i] <= 1'b0;
        end
      end
      if (w_issue) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR'(1);
      end
      // When full, tail equals head: the new entry reuses the slot just popped.
      if (w_dp_acc) begin
        r_valid[r_tail]   <= 1'b1;
        r_src1[r_tail]    <= w_dp_src1;
        r_vld1[r_tail]    <= w_dp_vld1;
        r_src2[r_tail]    <= w_dp_src2;
        r_vld2[r_tail]    <= w_dp_vld2;
        r_specbit[r_tail] <= w_dp_specbit;
        r_info[r_tail]    <= '{pc: dp_pc, imm: dp_imm, praddr: dp_praddr,
                               rrftag: dp_rrftag, dstval: dp_dstval,
                               alu_op: dp_alu_op, opcode: dp_opcode,
                               spectag: dp_spectag};
        r_tail            <= r_tail + PTR'(1);
      end
      r_count <= r_count + CNT'(w_dp_acc) - CNT'(w_issue);
    end
  end

  assign full       = w_full;
  assign count      = r_count;
  assign issue      = w_issue;
  assign ex_src1    = r_src1[r_head];
  assign ex_src2    = r_src2[r_head];
  assign ex_pc      = r_info[r_head].pc;
  assign ex_imm     = r_info[r_head].imm;
  assign ex_praddr  = r_info[r_head].praddr;
  assign ex_rrftag  = r_info[r_head].rrftag;
  assign ex_dstval  = r_info[r_head].dstval;
  assign ex_alu_op  = r_info[r_head].alu_op;
  assign ex_opcode  = r_info[r_head].opcode;
  assign ex_spectag = r_info[r_head].spectag;
  assign ex_specbit = r_specbit[r_head];

  a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (reset)
    !(dp_we && w_full && !w_issue && !prmiss));

endmodule

// File: tb/tb_rs_branch_queue.sv
// Bench for rs_branch_queue: directed scenarios with literal expectations,
// then randomized traffic against a queue-based behavioural model.
module tb_rs_branch_queue;
  import rs_branch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic dp_we, dp_vld1, dp_vld2, dp_dstval, dp_specbit;
  logic [31:0] dp_pc, dp_praddr, dp_imm, dp_src1, dp_src2;
  logic [5:0] dp_rrftag;
  logic [3:0] dp_alu_op;
  logic [6:0] dp_opcode;
  logic [4:0] dp_spectag, pr_tag;
  logic cdb0_we, cdb1_we, prmiss, prsuccess;
  logic [5:0] cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_data, cdb1_data;
  logic full, issue, ex_dstval, ex_specbit;
  logic [2:0] count;
  logic [31:0] ex_src1, ex_src2, ex_pc, ex_imm, ex_praddr;
  logic [5:0] ex_rrftag;
  logic [3:0] ex_alu_op;
  logic [6:0] ex_opcode;
  logic [4:0] ex_spectag;

  rs_branch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .dp_we(dp_we), .dp_pc(dp_pc), .dp_praddr(dp_praddr),
    .dp_imm(dp_imm), .dp_src1(dp_src1), .dp_src2(dp_src2), .dp_vld1(dp_vld1),
    .dp_vld2(dp_vld2), .dp_rrftag(dp_rrftag), .dp_dstval(dp_dstval),
    .dp_alu_op(dp_alu_op), .dp_opcode(dp_opcode), .dp_spectag(dp_spectag),
    .dp_specbit(dp_specbit), .cdb0_we(cdb0_we), .cdb0_tag(cdb0_tag),
    .cdb0_data(cdb0_data), .cdb1_we(cdb1_we), .cdb1_tag(cdb1_tag),
    .cdb1_data(cdb1_data), .prmiss(prmiss), .prsuccess(prsuccess), .pr_tag(pr_tag),
    .full(full), .count(count), .issue(issue), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_praddr(ex_praddr), .ex_rrftag(ex_rrftag),
    .ex_dstval(ex_dstval), .ex_alu_op(ex_alu_op), .ex_opcode(ex_opcode),
    .ex_spectag(ex_spectag), .ex_specbit(ex_specbit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s1, s2, pc, imm, pra;
    logic v1, v2, dst, sb;
    logic [5:0] rrf;
    logic [3:0] op;
    logic [6:0] opc;
    logic [4:0] st;
  } ent_t;

  ent_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // An operand not yet valid picks up the first bus carrying its tag.
  function automatic void wake(inout logic [31:0] v, inout logic vl);
    if (vl) return;
    if (cdb0_we && cdb0_tag == v[5:0]) begin v = cdb0_data; vl = 1'b1; end
    else if (cdb1_we && cdb1_tag == v[5:0]) begin v = cdb1_data; vl = 1'b1; end
  endfunction

  function automatic bit model_issue();
    return !reset && !prmiss && q.size() > 0 && q[0].v1 && q[0].v2;
  endfunction

  task automatic idle();
    reset = 0; dp_we = 0; dp_vld1 = 1; dp_vld2 = 1; dp_dstval = 0; dp_specbit = 0;
    dp_pc = 0; dp_praddr = 0; dp_imm = 0; dp_src1 = 0; dp_src2 = 0; dp_rrftag = 0;
    dp_alu_op = 0; dp_opcode = RV32_BRANCH; dp_spectag = 5'b00001;
    cdb0_we = 0; cdb1_we = 0; cdb0_tag = 0; cdb1_tag = 0; cdb0_data = 0; cdb1_data = 0;
    prmiss = 0; prsuccess = 0; pr_tag = 0;
  endtask

  task automatic compare();
    bit ei;
    ei = model_issue();
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("issue", 32'(issue), 32'(ei));
    if (ei) begin
      $display("issue pc=0x%0h src1=0x%0h src2=0x%0h specbit=%0d", ex_pc, ex_src1, ex_src2, ex_specbit);
      chk("ex_src1", ex_src1, q[0].s1);
      chk("ex_src2", ex_src2, q[0].s2);
      chk("ex_pc", ex_pc, q[0].pc);
      chk("ex_imm", ex_imm, q[0].imm);
      chk("ex_praddr", ex_praddr, q[0].pra);
      chk("ex_rrftag", 32'(ex_rrftag), 32'(q[0].rrf));
      chk("ex_dstval", 32'(ex_dstval), 32'(q[0].dst));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(q[0].op));
      chk("ex_opcode", 32'(ex_opcode), 32'(q[0].opc));
      chk("ex_spectag", 32'(ex_spectag), 32'(q[0].st));
      chk("ex_specbit", 32'(ex_specbit), 32'(q[0].sb));
    end
  endtask

  task automatic model_step();
    bit ei;
    int sz;
    ent_t e;
    if (reset || prmiss) begin
      q.delete();
      return;
    end
    ei = model_issue();
    sz = q.size();
    foreach (q[i]) begin
      wake(q[i].s1, q[i].v1);
      wake(q[i].s2, q[i].v2);
      if (prsuccess && q[i].st == pr_tag) q[i].sb = 1'b0;
    end
    if (ei) void'(q.pop_front());
    if (dp_we && (sz < DEPTH || ei)) begin
      e.s1 = dp_src1; e.v1 = dp_vld1; e.s2 = dp_src2; e.v2 = dp_vld2;
      wake(e.s1, e.v1);
      wake(e.s2, e.v2);
      e.pc = dp_pc; e.imm = dp_imm; e.pra = dp_praddr; e.rrf = dp_rrftag;
      e.dst = dp_dstval; e.op = dp_alu_op; e.opc = dp_opcode; e.st = dp_spectag;
      e.sb = dp_specbit && !(prsuccess && dp_spectag == pr_tag);
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    #1;
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
    idle();
  endtask

  task automatic disp(input logic [31:0] pc, input logic [31:0] s1, input logic v1,
                      input logic [4:0] st, input logic sb);
    dp_we = 1; dp_pc = pc; dp_src1 = s1; dp_vld1 = v1; dp_src2 = pc + 1; dp_vld2 = 1;
    dp_imm = pc ^ 32'hA5; dp_praddr = pc + 32'h40; dp_rrftag = pc[7:2];
    dp_alu_op = pc[5:2]; dp_spectag = st; dp_specbit = sb; dp_dstval = pc[2];
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_issue", 32'(issue), 0);

    // 1: ready branch issues the cycle after dispatch
    disp(32'h100, 32'h11, 1, 5'b00001, 0);
    cycle();
    #1;
    chk("t1_issue", 32'(issue), 1);
    chk("t1_pc", ex_pc, 32'h100);
    chk("t1_count", 32'(count), 1);
    cycle();
    #1;
    chk("t1_empty", 32'(count), 0);

    // 2: src1 waits on tag 5, woken by cdb0
    disp(32'h200, 32'h5, 0, 5'b00001, 0);
    cycle();
    cdb0_we = 1; cdb0_tag = 6'd5; cdb0_data = 32'h1234;
    #1;
    chk("t2_noissue", 32'(issue), 0);
    cycle();
    #1;
    chk("t2_issue", 32'(issue), 1);
    chk("t2_src1", ex_src1, 32'h1234);
    cycle();

    // 3: fill behind a blocked head, then dispatch+issue while full
    disp(32'h300, 32'd20, 0, 5'b00001, 0); cycle();
    for (int k = 1; k < 4; k++) begin
      disp(32'h300 + 32'(4 * k), 32'h0, 1, 5'b00001, 0);
      cycle();
    end
    #1;
    chk("t3_full", 32'(full), 1);
    chk("t3_noissue", 32'(issue), 0);
    cdb0_we = 1; cdb0_tag = 6'd20; cdb0_data = 32'h55;
    cycle();
    disp(32'h310, 32'h0, 1, 5'b00001, 0);
    #1;
    chk("t3_issue", 32'(issue), 1);
    chk("t3_pc", ex_pc, 32'h300);
    cycle();
    #1;
    chk("t3_count", 32'(count), 4);
    chk("t3_order", ex_pc, 32'h304);
    repeat (5) cycle();

    // 5: misprediction flushes three entries and drops the dispatch
    for (int k = 0; k < 3; k++) begin
      disp(32'h500 + 32'(4 * k), 32'd40, 0, 5'b00001, 0);
      cycle();
    end
    prmiss = 1;
    disp(32'h520, 32'h0, 1, 5'b00001, 0);
    prmiss = 1;
    #1;
    chk("t5_issue", 32'(issue), 0);
    chk("t5_count", 32'(count), 3);
    cycle();
    #1;
    chk("t5_flushed", 32'(count), 0);
    cycle();

    // 6: prsuccess clears specbit on matching entries while they wake
    disp(32'h600, 32'd7, 0, 5'b00010, 1); cycle();
    disp(32'h604, 32'd7, 0, 5'b00010, 1); cycle();
    prsuccess = 1; pr_tag = 5'b00010;
    cdb0_we = 1; cdb0_tag = 6'd7; cdb0_data = 32'hAB;
    cycle();
    #1;
    chk("t6_issue_a", 32'(issue), 1);
    chk("t6_spec_a", 32'(ex_specbit), 0);
    cycle();
    #1;
    chk("t6_issue_b", 32'(issue), 1);
    chk("t6_spec_b", 32'(ex_specbit), 0);
    chk("t6_src1", ex_src1, 32'hAB);
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] s;
      reset = ($urandom_range(0, 199) == 0);
      prmiss = ($urandom_range(0, 29) == 0);
      prsuccess = !prmiss && ($urandom_range(0, 9) == 0);
      pr_tag = 5'b00001 << $urandom_range(0, 4);
      cdb0_we = ($urandom_range(0, 2) == 0);
      cdb0_tag = 6'($urandom_range(0, 7));
      cdb0_data = $urandom();
      cdb1_we = ($urandom_range(0, 2) == 0);
      cdb1_tag = 6'($urandom_range(0, 7));
      cdb1_data = (cdb1_we && cdb0_we && cdb1_tag == cdb0_tag) ? cdb0_data : $urandom();
      dp_vld1 = $urandom_range(0, 1); dp_vld2 = $urandom_range(0, 1);
      s = $urandom(); s[5:0] = 6'($urandom_range(0, 7)); dp_src1 = s;
      s = $urandom(); s[5:0] = 6'($urandom_range(0, 7)); dp_src2 = s;
      dp_pc = $urandom(); dp_praddr = $urandom(); dp_imm = $urandom();
      dp_rrftag = 6'($urandom()); dp_dstval = $urandom_range(0, 1);
      dp_alu_op = 4'($urandom()); dp_opcode = 7'($urandom());
      dp_spectag = 5'b00001 << $urandom_range(0, 4); dp_specbit = $urandom_range(0, 1);
      dp_we = ($urandom_range(0, 9) < 6) && (q.size() < DEPTH || model_issue());
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
